// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op codes, HI/LO read selects, default latencies and E/M write-back sources.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic RD_HI = 1'b0;
  localparam logic RD_LO = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // E/M pipeline register write-back source; WB_MD captures md_out for MFHI/MFLO.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC8 = 2'd2,
    WB_MD  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/md_unit_e_if.sv
// Request/read bundle between the E stage (master) and the multiply/divide unit (slave).
interface md_unit_e_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output start, md_op, a, b, rd_sel,
    input  busy, hi, lo, md_out
  );

  modport slave (
    input  start, md_op, a, b, rd_sel,
    output busy, hi, lo, md_out
  );
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result for a latched multiply/divide operation.
// Signed divide works on magnitudes, then fixes quotient and remainder signs.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] b_safe;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign prod_u = {32'b0, a} * {32'b0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // A zero divisor never reaches the dividers; the commit is suppressed instead.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign abs_a  = a[31] ? -a : a;
  assign abs_b  = b_safe[31] ? -b_safe : b_safe;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo = (a[31] ^ b[31]) ? -q_mag : q_mag;
        res_hi = a[31] ? -r_mag : r_mag;
      end
      MD_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_e.sv
// Execute-stage multiply/divide unit: HI/LO registers, operand latches and a
// busy down-counter that models multi-cycle latency for the hazard unit.
//
//   state   | meaning
//   IDLE    | cnt == 0; accepts start, MTHI/MTLO write immediately
//   BUSY    | cnt != 0; counts down, commits result as cnt goes 1 -> 0
module md_unit_e
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic        clk,
  input logic        rst,
  md_unit_e_if.slave bus
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  md_op_e           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign state = (cnt != '0) ? ST_BUSY : ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= MD_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              MD_MULT, MD_MULTU: begin
                op_q <= md_op_e'(bus.md_op);
                a_q  <= bus.a;
                b_q  <= bus.b;
                cnt  <= CNT_W'(MULT_CYCLES);
              end
              MD_DIV, MD_DIVU: begin
                op_q <= md_op_e'(bus.md_op);
                a_q  <= bus.a;
                b_q  <= bus.b;
                cnt  <= CNT_W'(DIV_CYCLES);
              end
              MD_MTHI: hi_q <= bus.a;
              MD_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        default: begin
          cnt <= cnt - 1'b1;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (cnt == CNT_W'(1) && !div_zero) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state == ST_BUSY);
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = (bus.rd_sel == RD_LO) ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit_e.sv
// Directed self-checking bench for md_unit_e: latencies, arithmetic results,
// divide-by-zero, MTHI/MTLO, operand latching, reset abort and back-to-back starts.
module tb_md_unit_e;
  import md_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  md_unit_e_if bus ();

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit must never present start while busy.
  always @(negedge clk) begin
    if (!rst && bus.start && bus.busy) begin
      miscompares++;
      $display("FAIL start_while_busy: start=%0b busy=%0b required no overlap", bus.start, bus.busy);
    end
  end

  // Issues one op, scrambles operands afterwards, and counts busy cycles and
  // any HI/LO change observed while still busy.
  task automatic run_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output int early);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = ~x;
    bus.b     = y + 32'd1;
    cyc   = 0;
    early = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      if (bus.hi !== hi0 || bus.lo !== lo0) early++;
      @(posedge clk); #1;
    end
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [31:0] val);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = val;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = 32'hDEAD_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h required 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h required 00000000", bus.lo); end
    vectors++; if (bus.md_out !== 32'd0) begin miscompares++; $display("FAIL reset_md_out: got %h required 00000000", bus.md_out); end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int cyc, early;
    run_md(MD_MULT, 32'hFFFF_FFFF, 32'd2, cyc, early);
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d required 5", cyc); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL mult_early_commit: got %0d changes required 0", early); end
    vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h required ffffffff", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mult_lo: got %h required fffffffe", bus.lo); end
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2, cyc, early);
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d required 5", cyc); end
    vectors++; if (bus.hi !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_hi: got %h required 00000001", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_lo: got %h required fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    int cyc, early;
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc, early);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL div_busy_cycles: got %0d required 10", cyc); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL div_early_commit: got %0d changes required 0", early); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo: got %h required fffffffd", bus.lo); end
    vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi: got %h required ffffffff", bus.hi); end
    run_md(MD_DIVU, 32'hFFFF_FFF9, 32'd2, cyc, early);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL divu_busy_cycles: got %0d required 10", cyc); end
    vectors++; if (bus.lo !== 32'h7FFF_FFFC) begin miscompares++; $display("FAIL divu_lo: got %h required 7ffffffc", bus.lo); end
    vectors++; if (bus.hi !== 32'h0000_0001) begin miscompares++; $display("FAIL divu_hi: got %h required 00000001", bus.hi); end
  endtask

  task automatic test_div_zero();
    int cyc, early;
    mt_write(MD_MTHI, 32'h1234_5678);
    mt_write(MD_MTLO, 32'h9ABC_DEF0);
    vectors++; if (bus.hi !== 32'h1234_5678) begin miscompares++; $display("FAIL preload_hi: got %h required 12345678", bus.hi); end
    vectors++; if (bus.lo !== 32'h9ABC_DEF0) begin miscompares++; $display("FAIL preload_lo: got %h required 9abcdef0", bus.lo); end
    run_md(MD_DIV, 32'h0000_0064, 32'd0, cyc, early);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL divz_busy_cycles: got %0d required 10", cyc); end
    vectors++; if (bus.hi !== 32'h1234_5678) begin miscompares++; $display("FAIL divz_hi: got %h required 12345678", bus.hi); end
    vectors++; if (bus.lo !== 32'h9ABC_DEF0) begin miscompares++; $display("FAIL divz_lo: got %h required 9abcdef0", bus.lo); end
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, early);
    vectors++; if (bus.lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_lo: got %h required 80000000", bus.lo); end
    vectors++; if (bus.hi !== 32'h0000_0000) begin miscompares++; $display("FAIL div_ovf_hi: got %h required 00000000", bus.hi); end
  endtask

  task automatic test_mt();
    bus.rd_sel = RD_HI;
    mt_write(MD_MTHI, 32'hCAFE_BABE);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy: got %0b required 0", bus.busy); end
    vectors++; if (bus.md_out !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL mthi_md_out: got %h required cafebabe", bus.md_out); end
    @(posedge clk); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy_later: got %0b required 0", bus.busy); end
    mt_write(MD_MTLO, 32'h0BAD_F00D);
    bus.rd_sel = RD_LO; #1;
    vectors++; if (bus.md_out !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL mtlo_md_out: got %h required 0badf00d", bus.md_out); end
    bus.rd_sel = RD_HI; #1;
    vectors++; if (bus.md_out !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL mtlo_hi_kept: got %h required cafebabe", bus.md_out); end
  endtask

  task automatic test_operand_latch();
    int cyc;
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.a     = 32'hFFFF_FFFD;
    bus.b     = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      bus.a = 32'd100 + 32'(cyc);
      bus.b = 32'd7;
      @(posedge clk); #1;
    end
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL latch_busy_cycles: got %0d required 5", cyc); end
    vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL latch_hi: got %h required ffffffff", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL latch_lo: got %h required fffffff1", bus.lo); end
  endtask

  task automatic test_undefined_op();
    bus.start = 1'b1;
    bus.md_op = 3'd7;
    bus.a     = 32'h5555_5555;
    @(posedge clk); #1;
    bus.md_op = 3'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL undef_busy: got %0b required 0", bus.busy); end
    vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL undef_hi: got %h required ffffffff", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL undef_lo: got %h required fffffff1", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int cyc, early;
    run_md(MD_MULT, 32'd7, 32'd6, cyc, early);
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL b2b_first_cycles: got %0d required 5", cyc); end
    vectors++; if (bus.lo !== 32'd42) begin miscompares++; $display("FAIL b2b_first_lo: got %h required 0000002a", bus.lo); end
    run_md(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, early);
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL b2b_second_cycles: got %0d required 5", cyc); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL b2b_second_hi: got %h required 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'd1) begin miscompares++; $display("FAIL b2b_second_lo: got %h required 00000001", bus.lo); end
  endtask

  task automatic test_reset_mid_op();
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %0b required 0", bus.busy); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL rstmid_hi: got %h required 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL rstmid_lo: got %h required 00000000", bus.lo); end
    repeat (12) begin @(posedge clk); #1; end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_later: got %0b required 0", bus.busy); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL rstmid_hi_later: got %h required 00000000", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL rstmid_lo_later: got %h required 00000000", bus.lo); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.md_op   = 3'd0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    bus.rd_sel  = RD_HI;
    test_reset();
    @(posedge clk); #1;
    test_mult();
    test_div();
    test_div_zero();
    test_mt();
    test_operand_latch();
    test_undefined_op();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit_e.md
# md_unit_e

Execute-stage multiply/divide unit for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds the architectural HI/LO registers. It models multi-cycle latency with a busy counter, which the hazard unit uses to stall MD-class instructions in D. It supplies the HI/LO read value that the E/M pipeline register captures as the MD write-back source for MFHI/MFLO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU
- DIV_CYCLES, 10, busy duration for DIV/DIVU

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  qualifies md_op this cycle; asserted by E only when its instruction is MD-class and not stalled
- md_op  in  3  operation code from the shared package
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- rd_sel  in  1  read select: 0 = HI, 1 = LO
- busy  out  1  high while an operation is in progress
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  combinational `rd_sel ? lo : hi`

## Operation
State machine:
- Two states, IDLE and BUSY. State is implied by a counter `cnt` wide enough for DIV_CYCLES.
- `busy = (cnt != 0)`.

In IDLE with start=1:
- MULT/MULTU/DIV/DIVU:
  - Latch md_op, a and b internally, so operands may change afterwards.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO:
  - Write a into hi or lo at that edge.
  - `cnt` stays 0 and busy is never raised.
- MD_NONE or an undefined code: no effect.

In BUSY:
- `cnt` decrements every cycle.
- On the edge where `cnt` goes 1→0, commit the result to hi/lo.
- start is ignored while busy. The hazard unit guarantees this does not occur; the bench asserts it.

Arithmetic:
- MULTU: {hi,lo} = 64-bit unsigned a·b.
- MULT: {hi,lo} = 64-bit two's-complement a·b.
- DIVU: lo = a/b, hi = a%b, both unsigned.
- DIV:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero (b = 0, DIV or DIVU):
  - hi and lo are left unchanged at commit.
  - Busy still lasts the full DIV_CYCLES.

Reset:
- `cnt` = 0, busy = 0, hi = 0, lo = 0, latched operands = 0.
- Reset mid-operation aborts it. No commit occurs and hi/lo read 0 the following cycle.

## Timing
Multiply/divide start at edge T:
- busy is high for exactly N cycles, from T+1 through T+N.
- hi/lo take the new value at edge T+N, the same edge at which busy falls.
- A start in the cycle after busy falls is accepted.

MTHI/MTLO at edge T:
- hi/lo change at T.
- md_out reflects the new value in cycle T+1.

Reads:
- md_out is purely combinational from the registers, with no internal forwarding.
- The hazard unit stalls MFHI/MFLO in D while `start | busy`.

## Structure
- Shared package `md_pkg` holds:
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - The rd_sel encodings.
  - Default cycle counts.
  - The E/M write-back source encodings that select md_out.
- One combinational sub-module `md_arith`:
  - Inputs: latched op, a, b.
  - Outputs: {res_hi, res_lo} and a div_zero flag.
- The top level holds the counter, latches and HI/LO registers.

## Test plan
1. **MULT and MULTU.**
   - MULT a=0xFFFFFFFF, b=2 → busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
   - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
2. **DIV and DIVU.**
   - DIV a=0xFFFFFFF9 (−7), b=2 → busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
3. **Divide by zero.**
   - Preload via MTHI 0x12345678 and MTLO 0x9ABCDEF0.
   - DIV b=0 → busy 10 cycles; hi/lo remain 0x12345678/0x9ABCDEF0.
   - Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. **MTHI/MTLO with operand change.**
   - MTHI 0xCAFEBABE → busy never asserts; md_out with rd_sel=0 is 0xCAFEBABE next cycle.
   - Change a during a MULT busy window → the result uses the latched a.
5. **Reset and back-to-back starts.**
   - Reset during cycle 3 of a DIV → busy=0 next cycle, hi=lo=0, no later commit.
   - Back-to-back: a second MULT started the cycle after busy falls → accepted, busy again for 5 cycles.
